// File: rtl/aes_key_schedule_store.sv
// aes_key_schedule_store
//   Iterative AES-128 key expander plus an 11-entry round-key buffer that feeds
//   the inverse-round datapath. Pulsing key_load in IDLE or READY captures the
//   cipher key into slot 0. One further slot is then derived per clock, so slots
//   1..10 are ready 10 edges after the load edge. Keys are read by round index
//   in any order.
//
//   Build option: define AES_KEY_ZEROIZE_EN to add the zeroize input. A zeroize
//   request clears all slots, aborts any expansion and returns the block to IDLE.
//
//   Ports
//     clk, rst      clock; synchronous active-high reset
//     zeroize       (AES_KEY_ZEROIZE_EN only) wipe storage and abort
//     key_in        128-bit cipher key; w0 = key_in[127:96]
//     key_load      start-expansion strobe (ignored while busy)
//     busy          expansion in progress
//     keys_valid    all 11 round keys stored and readable
//     expand_done   single-cycle pulse on the edge that writes slot 10
//     rd_idx        round-key index 0..10
//     rd_key        selected round key; 0 if not valid or index > 10
//   Parameter
//     RD_REGISTERED 1: rd_key is registered (1-cycle latency), 0: combinational

// Forward AES S-box, computed as the GF(2^8) inverse followed by the affine map.
module aes_key_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and 0 maps to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  logic [7:0] inv;
  assign inv = ginv(a_i);
  assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_schedule_store #(
  parameter int RD_REGISTERED = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         keys_valid,
  output logic         expand_done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 kv_q, kv_d;
  logic                 done_q, done_d;
  logic [10:0][127:0]   keys_q;
  logic                 load_go, exp_we;
  logic                 zero_w;

`ifdef AES_KEY_ZEROIZE_EN
  assign zero_w = zeroize;
`else
  assign zero_w = 1'b0;
`endif

  // ---------------------------------------------------------------- expansion
  logic [3:0]   prev_idx;
  logic [127:0] prev_key, nxt_key;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [7:0]   rcon;

  // cnt_q is 1..10 whenever the expansion result is used.
  assign prev_idx = cnt_q - 4'd1;
  assign prev_key = keys_q[prev_idx];
  assign rot_w    = {prev_key[23:0], prev_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_key_sbox u_sbox (.a_i(rot_w[g*8 +: 8]), .s_o(sub_w[g*8 +: 8]));
  end

  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_w     = sub_w ^ {rcon, 24'h0};
  assign w0n     = prev_key[127:96] ^ t_w;
  assign w1n     = prev_key[95:64]  ^ w0n;
  assign w2n     = prev_key[63:32]  ^ w1n;
  assign w3n     = prev_key[31:0]   ^ w2n;
  assign nxt_key = {w0n, w1n, w2n, w3n};

  // ---------------------------------------------------------------- control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    kv_d    = kv_q;
    done_d  = 1'b0;
    load_go = 1'b0;
    exp_we  = 1'b0;
    if (zero_w) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      busy_d  = 1'b0;
      kv_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (key_load) begin
            load_go = 1'b1;
            state_d = EXPAND;
            cnt_d   = 4'd1;
            busy_d  = 1'b1;
            kv_d    = 1'b0;
          end
        end
        EXPAND: begin
          // key_load is deliberately not looked at here.
          exp_we = 1'b1;
          if (cnt_q == 4'd10) begin
            state_d = READY;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
            kv_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      kv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      kv_q    <= kv_d;
      done_q  <= done_d;
    end
  end

  // Storage is not reset; keys_valid gates every read instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (zero_w)       keys_q         <= '0;
      else if (load_go) keys_q[0]      <= key_in;
      else if (exp_we)  keys_q[cnt_q]  <= nxt_key;
    end
  end

  assign busy        = busy_q;
  assign keys_valid  = kv_q;
  assign expand_done = done_q;

  // ---------------------------------------------------------------- read path
  logic [127:0] rd_sel;
  assign rd_sel = (kv_q && (rd_idx <= 4'd10)) ? keys_q[rd_idx] : '0;

  if (RD_REGISTERED != 0) begin : g_rd_reg
    logic [127:0] rd_key_q;
    // A load edge drops keys_valid, so the stale key must not be captured there.
    always_ff @(posedge clk) begin
      if (rst)                    rd_key_q <= '0;
      else if (zero_w || load_go) rd_key_q <= '0;
      else                        rd_key_q <= rd_sel;
    end
    assign rd_key = rd_key_q;
  end else begin : g_rd_comb
    assign rd_key = rd_sel;
  end
endmodule
